modred_solinas_pipe: RTL and testbench

//  Streaming modular reducer for Solinas primes q = 2^LOGQ - 2^SHIFT + 1.

---
 rtl/modred_solinas_pipe.sv | 139 +++++++++++++
 tb/tb_modred_solinas_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modred_solinas_pipe.sv
// Streaming reducer mod Solinas prime q = 2^LOGQ - 2^SHIFT + 1: NFOLD registered folds, one conditional-subtract stage.
// Valid/ready with sideband tag. Define MODRED_CHECK_EN for a simulation-only shadow golden pipe driving CHK_ERR.
module modred_solinas_pipe #(
    parameter int unsigned     LOGQ  = 28,
    parameter int unsigned     SHIFT = 16,
    parameter longint unsigned PRIME = (64'd1 << LOGQ) - (64'd1 << SHIFT) + 64'd1,
    parameter int unsigned     NFOLD = 3,
    parameter int unsigned     TAG_W = 8
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [2*LOGQ-1:0] DATA_IN,
    input  logic [TAG_W-1:0]  TAG_IN,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [LOGQ-1:0]   DATA_OUT,
    output logic [TAG_W-1:0]  TAG_OUT,
    output logic              CHK_ERR
);

    localparam int unsigned     W         = 2*LOGQ + 1;
    localparam int unsigned     FW        = LOGQ + 2;
    localparam longint unsigned PRIME_EXP = (64'd1 << LOGQ) - (64'd1 << SHIFT) + 64'd1;
    localparam logic [FW-1:0]   PRIME_F   = FW'(PRIME);

    if (SHIFT >= LOGQ || SHIFT == 32'd0 || PRIME != PRIME_EXP) begin : g_bad_param
        $error("modred_solinas_pipe: PRIME must equal 2**LOGQ-2**SHIFT+1 with 0 < SHIFT < LOGQ");
    end

    // 2^LOGQ == 2^SHIFT - 1 (mod q), so the high half folds back as hi*(2^SHIFT-1); never negative.
    function automatic logic [W-1:0] solinas_fold(input logic [W-1:0] x);
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        lo = {{(W-LOGQ){1'b0}}, x[LOGQ-1:0]};
        hi = {{LOGQ{1'b0}}, x[W-1:LOGQ]};
        return lo + (hi << SHIFT) - hi;
    endfunction

    logic [W-1:0]     fold_q [NFOLD];
    logic [W-1:0]     fold_d [NFOLD];
    logic [TAG_W-1:0] ftag_q [NFOLD];
    logic [NFOLD-1:0] fvld_q;
    logic             out_vld_q;
    logic [LOGQ-1:0]  out_data_q;
    logic [LOGQ-1:0]  out_data_d;
    logic [TAG_W-1:0] out_tag_q;
    logic             en_s;
    logic [FW-1:0]    fin_x_s;
    logic [FW-1:0]    fin_d_s;

    assign en_s      = OUT_READY | ~out_vld_q;
    assign IN_READY  = en_s;
    assign OUT_VALID = out_vld_q;
    assign DATA_OUT  = out_data_q;
    assign TAG_OUT   = out_tag_q;

    // Fold chain next-state and final conditional subtract.
    always_comb begin
        fold_d[0] = solinas_fold({1'b0, DATA_IN});
        for (int f = 1; f < NFOLD; f++) begin
            fold_d[f] = solinas_fold(fold_q[f-1]);
        end
        // Last fold output is < 2*PRIME, so LOGQ+2 bits hold it and the signed difference.
        fin_x_s = fold_q[NFOLD-1][FW-1:0];
        fin_d_s = fin_x_s - PRIME_F;
        if (fin_d_s[FW-1]) begin
            out_data_d = fin_x_s[LOGQ-1:0];
        end else begin
            out_data_d = fin_d_s[LOGQ-1:0];
        end
    end

    // Pipeline registers: whole pipe shifts on en, bubbles included, holds otherwise.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fvld_q     <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_tag_q  <= '0;
            for (int f = 0; f < NFOLD; f++) begin
                fold_q[f] <= '0;
                ftag_q[f] <= '0;
            end
        end else if (en_s) begin
            fvld_q[0] <= IN_VALID;
            fold_q[0] <= fold_d[0];
            ftag_q[0] <= TAG_IN;
            for (int f = 1; f < NFOLD; f++) begin
                fvld_q[f] <= fvld_q[f-1];
                fold_q[f] <= fold_d[f];
                ftag_q[f] <= ftag_q[f-1];
            end
            out_vld_q  <= fvld_q[NFOLD-1];
            out_data_q <= out_data_d;
            out_tag_q  <= ftag_q[NFOLD-1];
        end
    end

`ifdef MODRED_CHECK_EN
    localparam logic [W-1:0] PRIME_W = W'(PRIME);

    logic [LOGQ-1:0]  gold_q [NFOLD+1];
    logic [TAG_W-1:0] gtag_q [NFOLD+1];
    logic [W-1:0]     gold_full_s;
    logic             chk_err_q;

    assign gold_full_s = {1'b0, DATA_IN} % PRIME_W;
    assign CHK_ERR     = chk_err_q;

    // Shadow golden pipe aligned with the output register; sticky mismatch flag on each handshake.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            chk_err_q <= 1'b0;
            for (int f = 0; f <= NFOLD; f++) begin
                gold_q[f] <= '0;
                gtag_q[f] <= '0;
            end
        end else begin
            if (en_s) begin
                gold_q[0] <= gold_full_s[LOGQ-1:0];
                gtag_q[0] <= TAG_IN;
                for (int f = 1; f <= NFOLD; f++) begin
                    gold_q[f] <= gold_q[f-1];
                    gtag_q[f] <= gtag_q[f-1];
                end
            end
            if (out_vld_q && OUT_READY &&
                (gold_q[NFOLD] != out_data_q || gtag_q[NFOLD] != out_tag_q)) begin
                chk_err_q <= 1'b1;
            end
        end
    end
`else
    assign CHK_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_modred_solinas_pipe.sv
// Directed self-checking bench for modred_solinas_pipe at default parameters (PRIME = 268369921).
module tb_modred_solinas_pipe;

    localparam logic [55:0] PRIME = 56'd268369921;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [55:0] data_in;
    logic [7:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [27:0] data_out;
    logic [7:0]  tag_out;
    logic        chk_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    modred_solinas_pipe dut (
        .CLK      (clk),
        .RSTN     (rstn),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .DATA_IN  (data_in),
        .TAG_IN   (tag_in),
        .OUT_VALID(out_valid),
        .OUT_READY(out_ready),
        .DATA_OUT (data_out),
        .TAG_OUT  (tag_out),
        .CHK_ERR  (chk_err)
    );

    task automatic test_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = 56'd0;
        tag_in    = 8'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || data_out !== 28'd0 || tag_out !== 8'd0 || chk_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%0d tag=%h chk=%b, required 0 0 00 0",
                     out_valid, data_out, tag_out, chk_err);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_latency();
        int lat = 0;
        in_valid  = 1'b1;
        data_in   = 56'd0;
        tag_in    = 8'h11;
        out_ready = 1'b1;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid === 1'b1) lat = c;
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required 4", lat);
        end
        checks++;
        if (data_out !== 28'd0 || tag_out !== 8'h11) begin
            errors++;
            $display("FAIL latency_data: got %0d tag %h, required 0 tag 11", data_out, tag_out);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [55:0] vin  [3];
        logic [27:0] vexp [3];
        int nin = 0, nout = 0, prev_c = 0, first_c = -1;
        vin[0] = 56'd268369921;  vexp[0] = 28'd0;
        vin[1] = 56'd268369920;  vexp[1] = 28'd268369920;
        vin[2] = 56'd268435456;  vexp[2] = 28'd65535;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (nin < 3) begin
                in_valid = 1'b1;
                data_in  = vin[nin];
                tag_in   = 8'h20 + 8'(nin);
                nin++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (nout < 3) begin
                    checks++;
                    if (data_out !== vexp[nout] || tag_out !== 8'h20 + 8'(nout)) begin
                        errors++;
                        $display("FAIL b2b_data[%0d]: got %0d tag %h, required %0d tag %h",
                                 nout, data_out, tag_out, vexp[nout], 8'h20 + 8'(nout));
                    end
                    if (nout > 0) begin
                        checks++;
                        if (c != prev_c + 1) begin
                            errors++;
                            $display("FAIL b2b_gap[%0d]: beat at cycle %0d, required %0d", nout, c, prev_c + 1);
                        end
                    end else begin
                        first_c = c;
                    end
                    prev_c = c;
                end
                nout++;
            end
        end
        checks++;
        if (nout != 3 || first_c != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats first at %0d, required 3 beats first at 3", nout, first_c);
        end
    endtask

    task automatic test_boundaries();
        logic [55:0] vin  [8];
        logic [27:0] vexp [8];
        int nin = 0, nout = 0;
        vin[0] = 56'd0;                                vexp[0] = 28'd0;
        vin[1] = 56'd1341849605;                       vexp[1] = 28'd0;
        vin[2] = 56'd268369921 * 56'd268369921;        vexp[2] = 28'd0;
        vin[3] = 56'd268369920 * 56'd268369920;        vexp[3] = 28'd1;
        vin[4] = {56{1'b1}};                           vexp[4] = 28'd917488;
        vin[5] = 56'd268369922;                        vexp[5] = 28'd1;
        vin[6] = 56'd12345;                            vexp[6] = 28'd12345;
        vin[7] = 56'd536870912;                        vexp[7] = 28'd131070;
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (nin < 8) begin
                in_valid = 1'b1;
                data_in  = vin[nin];
                tag_in   = 8'h40 + 8'(nin);
                nin++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (nout < 8) begin
                    checks++;
                    if (data_out !== vexp[nout] || tag_out !== 8'h40 + 8'(nout)) begin
                        errors++;
                        $display("FAIL boundary[%0d]: got %0d tag %h, required %0d tag %h",
                                 nout, data_out, tag_out, vexp[nout], 8'h40 + 8'(nout));
                    end
                end
                nout++;
            end
        end
        checks++;
        if (nout != 8 || chk_err !== 1'b0) begin
            errors++;
            $display("FAIL boundary_count: got %0d beats chk=%b, required 8 beats chk=0", nout, chk_err);
        end
    endtask

    task automatic test_stall_stream();
        logic        mvld [4];
        logic [27:0] mdat [4];
        logic [7:0]  mtag [4];
        logic [63:0] r64;
        logic        en_m;
        bit          hold_in = 1'b0;
        int sent = 0, rcv = 0, bad_ready = 0, bad_out = 0;
        for (int i = 0; i < 4; i++) begin
            mvld[i] = 1'b0; mdat[i] = 28'd0; mtag[i] = 8'd0;
        end
        for (int c = 0; c < 400 && rcv < 10; c++) begin
            if (out_valid !== mvld[3] || (mvld[3] && (data_out !== mdat[3] || tag_out !== mtag[3]))) begin
                bad_out++;
                if (bad_out == 1)
                    $display("FAIL stream_out: cycle %0d valid=%b data=%0d tag=%h, required %b %0d %h",
                             c, out_valid, data_out, tag_out, mvld[3], mdat[3], mtag[3]);
            end
            out_ready = 1'($urandom_range(0, 1));
            if (!hold_in) begin
                if (sent < 10) begin
                    r64      = {$urandom(), $urandom()};
                    in_valid = 1'($urandom_range(0, 1));
                    data_in  = r64[55:0];
                    tag_in   = 8'h80 + 8'(sent);
                end else begin
                    in_valid = 1'b0;
                end
            end
            #1;
            en_m = out_ready | ~mvld[3];
            if (in_ready !== en_m) bad_ready++;
            if (en_m) begin
                if (mvld[3]) rcv++;
                for (int i = 3; i > 0; i--) begin
                    mvld[i] = mvld[i-1]; mdat[i] = mdat[i-1]; mtag[i] = mtag[i-1];
                end
                mvld[0] = in_valid;
                mdat[0] = 28'(data_in % PRIME);
                mtag[0] = tag_in;
                if (in_valid) sent++;
            end
            hold_in = in_valid && !en_m;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (bad_out != 0) begin
            errors++;
            $display("FAIL stream_out_total: %0d bad cycles, required 0", bad_out);
        end
        checks++;
        if (bad_ready != 0) begin
            errors++;
            $display("FAIL stream_in_ready: %0d bad cycles, required 0", bad_ready);
        end
        checks++;
        if (sent != 10 || rcv != 10) begin
            errors++;
            $display("FAIL stream_count: sent %0d received %0d, required 10 and 10", sent, rcv);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_flush();
        int stale = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            data_in  = 56'd1000 + 56'(i);
            tag_in   = 8'hC0 + 8'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || data_out !== 28'd0 || tag_out !== 8'd0) begin
            errors++;
            $display("FAIL flush_reset: valid=%b data=%0d tag=%h, required 0 0 00", out_valid, data_out, tag_out);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL flush_stale: %0d cycles with OUT_VALID after reset, required 0", stale);
        end
        checks++;
        if (in_ready !== 1'b1 || chk_err !== 1'b0) begin
            errors++;
            $display("FAIL flush_final: in_ready=%b chk=%b, required 1 0", in_ready, chk_err);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_boundaries();
        test_stall_stream();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
